// File: rtl/exc_pkg.sv
// Exception type codes, CP0 ExcCode values and FSM states
// shared by the exception commit controller.
package exc_pkg;

  localparam logic [31:0] EXC_NONE           = 32'd0;
  localparam logic [31:0] EXC_INT            = 32'd1;
  localparam logic [31:0] EXC_INST_ADD_ERR   = 32'd2;
  localparam logic [31:0] EXC_OVF            = 32'd3;
  localparam logic [31:0] EXC_SYSCALL        = 32'd4;
  localparam logic [31:0] EXC_BREAK          = 32'd5;
  localparam logic [31:0] EXC_ERET           = 32'd6;
  localparam logic [31:0] EXC_RI             = 32'd7;
  localparam logic [31:0] EXC_DATA_ADD_ERR_L = 32'd8;
  localparam logic [31:0] EXC_DATA_ADD_ERR_S = 32'd9;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_DRAIN    = 2'd1;
  localparam state_t ST_COMMIT   = 2'd2;
  localparam state_t ST_REDIRECT = 2'd3;

  function automatic logic [4:0] exc_to_code(input logic [31:0] t);
    logic [4:0] c;
    c = CODE_INT;
    case (t)
      EXC_INST_ADD_ERR:   c = CODE_ADEL;
      EXC_OVF:            c = CODE_OV;
      EXC_SYSCALL:        c = CODE_SYS;
      EXC_BREAK:          c = CODE_BP;
      EXC_RI:             c = CODE_RI;
      EXC_DATA_ADD_ERR_L: c = CODE_ADEL;
      EXC_DATA_ADD_ERR_S: c = CODE_ADES;
      default:            c = CODE_INT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exc_commit_ctrl.sv
// Precise exception / ERET sequencer: drain the data bus,
// commit to CP0 in one cycle, flush and redirect fetch.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_type_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic        exc_in_ds_i,
  input  logic        mem_busy_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        redirect_ready_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        cp0_exc_we_o,
  output logic [4:0]  cp0_exccode_o,
  output logic [31:0] cp0_epc_o,
  output logic        cp0_bd_o,
  output logic        cp0_badvaddr_we_o,
  output logic [31:0] cp0_badvaddr_o,
  output logic        cp0_eret_o,
  output logic        busy_o
);

  import exc_pkg::*;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] typ_q;
  logic [31:0] pc_q;
  logic [31:0] bva_q;
  logic        ds_q;
  logic        pend_q;
  logic [31:0] rpc_q;

  logic        accept;
  logic        is_eret;
  logic [31:0] commit_rpc;

  assign accept = (state == ST_IDLE) && exc_valid_i &&
                  (exc_type_i != EXC_NONE) && !rst;
  assign is_eret = (typ_q == EXC_ERET);
  assign commit_rpc = is_eret ? cp0_epc_i : EXC_VECTOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      typ_q  <= 32'd0;
      pc_q   <= 32'd0;
      bva_q  <= 32'd0;
      ds_q   <= 1'b0;
      pend_q <= 1'b0;
      rpc_q  <= 32'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            typ_q <= exc_type_i;
            pc_q  <= exc_pc_i;
            bva_q <= exc_badvaddr_i;
            ds_q  <= exc_in_ds_i;
            state <= mem_busy_i ? ST_DRAIN : ST_COMMIT;
          end
        end
        ST_DRAIN: begin
          if (!mem_busy_i) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          cnt    <= CNT_INIT;
          rpc_q  <= commit_rpc;
          pend_q <= !redirect_ready_i;
          if (redirect_ready_i && CNT_INIT == 4'd0)
            state <= ST_IDLE;
          else
            state <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          if (redirect_ready_i) pend_q <= 1'b0;
          // exit needs both the handshake and an expired flush window
          if ((!pend_q || redirect_ready_i) && cnt == 4'd0)
            state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall_o           = 1'b0;
    flush_o           = 1'b0;
    redirect_valid_o  = 1'b0;
    redirect_pc_o     = 32'd0;
    cp0_exc_we_o      = 1'b0;
    cp0_exccode_o     = 5'd0;
    cp0_epc_o         = 32'd0;
    cp0_bd_o          = 1'b0;
    cp0_badvaddr_we_o = 1'b0;
    cp0_badvaddr_o    = 32'd0;
    cp0_eret_o        = 1'b0;
    unique case (state)
      ST_IDLE: stall_o = accept;
      ST_DRAIN: stall_o = 1'b1;
      ST_COMMIT: begin
        stall_o          = 1'b1;
        flush_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = commit_rpc;
        if (is_eret) begin
          cp0_eret_o = 1'b1;
        end else begin
          cp0_exc_we_o  = 1'b1;
          cp0_exccode_o = exc_to_code(typ_q);
          cp0_epc_o     = ds_q ? pc_q - 32'd4 : pc_q;
          cp0_bd_o      = ds_q;
        end
        if (typ_q == EXC_INST_ADD_ERR) begin
          cp0_badvaddr_we_o = 1'b1;
          cp0_badvaddr_o    = pc_q;
        end else if (typ_q == EXC_DATA_ADD_ERR_L ||
                     typ_q == EXC_DATA_ADD_ERR_S) begin
          cp0_badvaddr_we_o = 1'b1;
          cp0_badvaddr_o    = bva_q;
        end
      end
      ST_REDIRECT: begin
        stall_o          = 1'b1;
        flush_o          = (cnt != 4'd0);
        redirect_valid_o = pend_q;
        redirect_pc_o    = pend_q ? rpc_q : 32'd0;
      end
    endcase
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Sequences precise-exception and ERET handling for the MIPS core.
- Accepts the prioritised exception type produced at the MEM stage by the exception encoder.
- Stalls the pipeline until any outstanding data-bus transaction drains, then commits the exception in a single cycle: CP0 EPC/Cause/BadVAddr/EXL writes, pipeline flush, and a PC redirect handshake to the fetch unit.
- Sits between the exception encoder, CP0, the hazard unit and the fetch unit.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception except ERET.
- FLUSH_CYCLES, 1, number of cycles flush_o is held from COMMIT onward (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- exc_valid_i  in  1  MEM-stage instruction valid.
- exc_type_i  in  32  encoder output (EXC_* codes from exc_pkg).
- exc_pc_i  in  32  MEM-stage PC.
- exc_badvaddr_i  in  32  data address of the MEM-stage access.
- exc_in_ds_i  in  1  MEM-stage instruction is in a branch delay slot.
- mem_busy_i  in  1  data-bus transaction outstanding.
- cp0_epc_i  in  32  current CP0 EPC.
- redirect_ready_i  in  1  fetch unit accepts the redirect.
- stall_o  out  1  freeze IF..MEM.
- flush_o  out  1  kill IF..MEM contents.
- redirect_valid_o  out  1  redirect request.
- redirect_pc_o  out  32  redirect target.
- cp0_exc_we_o  out  1  one-cycle strobe: write EPC, Cause.ExcCode, Cause.BD, set Status.EXL.
- cp0_exccode_o  out  5  ExcCode.
- cp0_epc_o  out  32  EPC value.
- cp0_bd_o  out  1  Cause.BD.
- cp0_badvaddr_we_o  out  1  BadVAddr write strobe.
- cp0_badvaddr_o  out  32  BadVAddr value.
- cp0_eret_o  out  1  one-cycle strobe: clear Status.EXL.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE, flush counter 0, all captured registers 0, every output 0. Reset mid-sequence returns to IDLE next edge; no CP0 strobe and no redirect is issued.
- Accept condition (IDLE only): exc_valid_i && exc_type_i != EXC_NONE.
  - On accept, latch type, pc, badvaddr and ds.
  - stall_o is asserted combinationally in the accept cycle.
- FSM:
  - IDLE: accept && mem_busy_i -> DRAIN; accept && !mem_busy_i -> COMMIT; otherwise stay.
  - DRAIN: stall_o=1; stay while mem_busy_i=1; -> COMMIT on the first cycle mem_busy_i=0.
  - COMMIT (exactly 1 cycle):
    - stall_o=1, flush_o=1, redirect_valid_o=1.
    - Load counter with FLUSH_CYCLES-1.
    - Non-ERET: cp0_exc_we_o=1; cp0_epc_o = ds ? pc-32'd4 : pc (mod 2^32); cp0_bd_o = ds; cp0_exccode_o from map; redirect_pc_o = EXC_VECTOR.
    - BadVAddr: INST_ADD_ERR -> cp0_badvaddr_we_o=1, value = pc. DATA_ADD_ERR_L/S -> cp0_badvaddr_we_o=1, value = badvaddr.
    - ERET: cp0_eret_o=1; no other CP0 strobe; redirect_pc_o = cp0_epc_i sampled in COMMIT.
    - If redirect_ready_i=1 and counter==0 -> IDLE; otherwise -> REDIRECT.
  - REDIRECT:
    - stall_o=1.
    - flush_o=1 while counter!=0; counter decrements each cycle, saturating at 0.
    - redirect_valid_o and redirect_pc_o are held stable until the redirect_ready_i handshake, then deasserted.
    - -> IDLE when the handshake is done and the counter is 0.
- CP0 strobes are asserted only in COMMIT, never repeated.
- Exception inputs are ignored outside IDLE, because the pipeline is stalled or flushed.
- Latency: accept at cycle t with bus idle -> COMMIT at t+1; a new accept is possible at t+2 at the earliest (ready=1, FLUSH_CYCLES=1).
- All CP0 outputs are 0 when their strobe is 0.

Decomposition:
- exc_pkg:
  - EXC_* type constants: NONE 0, INT 1, INST_ADD_ERR 2, OVF 3, SYSCALL 4, BREAK 5, ERET 6, RI 7, DATA_ADD_ERR_L 8, DATA_ADD_ERR_S 9.
  - ExcCode constants: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
  - State enum.
  - Function exc_to_code(type) -> 5-bit ExcCode.
- No sub-module; a single FSM plus capture registers.

Test Plan:
- SYSCALL, pc=0x8000_1000, ds=0, bus idle, ready=1 -> next cycle: cp0_exc_we_o=1, exccode=8, epc=0x8000_1000, bd=0, redirect 0xBFC0_0380, flush 1 cycle; back in IDLE after 2 cycles.
- OVF in delay slot, pc=0x8000_0004 -> epc=0x8000_0000, bd=1, exccode=12.
- DATA_ADD_ERR_S, badvaddr=0x1234_5671, mem_busy_i high 3 cycles -> stall 4 cycles, then COMMIT with exccode=5, badvaddr_we=1, badvaddr=0x1234_5671.
- ERET with cp0_epc_i=0x8000_2000, redirect_ready_i low 2 cycles -> cp0_eret_o single pulse, cp0_exc_we_o=0, redirect_pc_o stable at 0x8000_2000 until ready; FLUSH_CYCLES=3 -> flush_o high exactly 3 cycles.
- INST_ADD_ERR at pc=0x0000_0003 -> exccode=4, badvaddr=0x0000_0003; a second exception presented during REDIRECT is ignored.
- rst asserted in DRAIN -> next cycle all outputs 0, IDLE, no CP0 strobe afterwards.
